// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and default datapath width.
package muldiv_pkg;
  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply or restoring divide
// on magnitudes. {hi,lo} holds product, or remainder/quotient, after ITERS steps.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             en,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  localparam int CW = $clog2(ITERS + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [WIDTH:0]   sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign rem_sh = {hi, lo[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, b_q};
  // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
  assign diff   = rem_sh[WIDTH-1:0] - b_q;
  assign last   = cnt == CW'(ITERS - 1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= is_div;
      cnt   <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        hi <= ge ? diff : rem_sh[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], ge};
      end else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit feeding HI/LO: FSM, sign fix-up,
// MADD/MSUB accumulate and registered one-cycle write-back.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HIIn,
  input  logic [WIDTH-1:0] LOIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] outHigh,
  output logic [WIDTH-1:0] outLow,
  output logic             HIWrite,
  output logic             LOWrite,
  output logic             DivByZero
);
  state_t state_q, state_d;

  logic             start_acc, is_signed, is_div, is_move, div_zero, sa, sb;
  logic             core_en, core_last;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2:0]       op_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] hin_q, lin_q;
  logic [2*WIDTH-1:0] prod, sprod, res;

  assign start_acc = (state_q == IDLE) && Start;
  assign is_signed = Op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  assign is_div    = Op inside {OP_DIV, OP_DIVU};
  assign is_move   = Op inside {OP_MTHI, OP_MTLO};
  assign div_zero  = is_div && (B == '0);
  assign sa        = is_signed & A[WIDTH-1];
  assign sb        = is_signed & B[WIDTH-1];
  assign a_mag     = sa ? -A : A;
  assign b_mag     = sb ? -B : B;
  assign Busy      = state_q != IDLE;

  muldiv_iter_core #(.WIDTH(WIDTH), .ITERS(ITERS)) u_core (
    .Clk    (Clk),
    .Rst    (Rst),
    .load   (start_acc),
    .en     (core_en),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .hi     (core_hi),
    .lo     (core_lo),
    .last   (core_last)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    core_en = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = (is_move || div_zero) ? WB : CALC;
      CALC: begin
        core_en = 1'b1;
        if (core_last) state_d = FIX;
      end
      FIX:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q  <= OP_MULT;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      hin_q <= '0;
      lin_q <= '0;
    end else if (start_acc) begin
      op_q  <= Op;
      sa_q  <= sa;
      sb_q  <= sb;
      hin_q <= HIIn;
      lin_q <= LOIn;
    end
  end

  // Remainder follows the dividend sign; quotient and product follow sign XOR.
  assign prod  = {core_hi, core_lo};
  assign sprod = (sa_q ^ sb_q) ? -prod : prod;

  always_comb begin
    res = sprod;
    case (op_q)
      OP_MADD: res = {hin_q, lin_q} + sprod;
      OP_MSUB: res = {hin_q, lin_q} - sprod;
      OP_DIV:  res = {(sa_q ? -core_hi : core_hi), ((sa_q ^ sb_q) ? -core_lo : core_lo)};
      OP_DIVU: res = prod;
      default: ;
    endcase
  end

  // Outputs are loaded on the edge entering WB, so they are valid during WB.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      outHigh   <= '0;
      outLow    <= '0;
      Done      <= 1'b0;
      HIWrite   <= 1'b0;
      LOWrite   <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      HIWrite   <= 1'b0;
      LOWrite   <= 1'b0;
      DivByZero <= 1'b0;
      if (start_acc && Op == OP_MTHI) begin
        outHigh <= A;
        HIWrite <= 1'b1;
        Done    <= 1'b1;
      end else if (start_acc && Op == OP_MTLO) begin
        outLow  <= A;
        LOWrite <= 1'b1;
        Done    <= 1'b1;
      end else if (start_acc && div_zero) begin
        outHigh   <= A;
        outLow    <= '1;
        HIWrite   <= 1'b1;
        LOWrite   <= 1'b1;
        DivByZero <= 1'b1;
        Done      <= 1'b1;
      end else if (state_q == FIX) begin
        {outHigh, outLow} <= res;
        HIWrite <= 1'b1;
        LOWrite <= 1'b1;
        Done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, Start;
  logic [2:0]  Op;
  logic [31:0] A, B, HIIn, LOIn;
  logic        Busy, Done, HIWrite, LOWrite, DivByZero;
  logic [31:0] outHigh, outLow;

  int n_cmp = 0;
  int n_bad = 0;

  int          r_lat;
  logic [31:0] r_hi, r_lo;
  logic        r_hw, r_lw, r_dz, r_bok, n_hw, n_lw, n_dn, n_by;

  always #5 Clk = ~Clk;

  mul_div_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HIIn(HIIn), .LOIn(LOIn), .Busy(Busy), .Done(Done),
    .outHigh(outHigh), .outLow(outLow), .HIWrite(HIWrite),
    .LOWrite(LOWrite), .DivByZero(DivByZero)
  );

  // Launch one op, scramble inputs after capture, sample until Done (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; HIIn = hi; LOIn = lo;
    @(posedge Clk);
    #1 Start = 1'b0; A = $urandom; B = $urandom; HIIn = $urandom; LOIn = $urandom;
    r_lat = -1; r_bok = 1'b1; r_hi = 'x; r_lo = 'x; r_hw = 'x; r_lw = 'x; r_dz = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge Clk);
      if (!Busy) r_bok = 1'b0;
      if (Done) begin
        r_lat = k; r_hi = outHigh; r_lo = outLow;
        r_hw = HIWrite; r_lw = LOWrite; r_dz = DivByZero;
        break;
      end
    end
    @(negedge Clk);
    n_hw = HIWrite; n_lw = LOWrite; n_dn = Done; n_by = Busy;
  endtask

  task automatic test_reset;
    Rst = 1'b1; Start = 1'b0; Op = OP_MULT; A = '0; B = '0; HIIn = '0; LOIn = '0;
    repeat (3) @(negedge Clk);
    n_cmp++; if ({Busy, Done, HIWrite, LOWrite, DivByZero} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 00000", {Busy, Done, HIWrite, LOWrite, DivByZero}); end
    n_cmp++; if ({outHigh, outLow} !== 64'h0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", {outHigh, outLow}); end
    Rst = 1'b0;
    @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h0, 32'h0);
    n_cmp++; if (r_lat !== 34) begin n_bad++; $display("FAIL mult_latency got %0d want 34", r_lat); end
    n_cmp++; if (r_bok !== 1'b1) begin n_bad++; $display("FAIL mult_busy got %b want 1", r_bok); end
    n_cmp++; if ({r_hi, r_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_bad++; $display("FAIL mult_result got %h want ffffffffffffffeb", {r_hi, r_lo}); end
    n_cmp++; if ({r_hw, r_lw, r_dz} !== 3'b110) begin
      n_bad++; $display("FAIL mult_strobes got %b want 110", {r_hw, r_lw, r_dz}); end
    n_cmp++; if ({n_hw, n_lw, n_dn, n_by} !== 4'b0) begin
      n_bad++; $display("FAIL mult_after_wb got %b want 0000", {n_hw, n_lw, n_dn, n_by}); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    n_cmp++; if ({r_hi, r_lo} !== 64'hFFFFFFFE_00000001) begin
      n_bad++; $display("FAIL multu_result got %h want fffffffe00000001", {r_hi, r_lo}); end
  endtask

  task automatic test_div;
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    n_cmp++; if (r_lat !== 34) begin n_bad++; $display("FAIL divu_latency got %0d want 34", r_lat); end
    n_cmp++; if ({r_hi, r_lo} !== {32'd2, 32'd14}) begin
      n_bad++; $display("FAIL divu_result got %h want 000000020000000e", {r_hi, r_lo}); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
    n_cmp++; if ({r_hi, r_lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_bad++; $display("FAIL div_neg got %h want fffffffffffffffd", {r_hi, r_lo}); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    n_cmp++; if ({r_hi, r_lo, r_dz} !== {64'h00000000_80000000, 1'b0}) begin
      n_bad++; $display("FAIL div_overflow got %h/%b want 0000000080000000/0", {r_hi, r_lo}, r_dz); end
  endtask

  task automatic test_div_by_zero;
    run_op(OP_DIVU, 32'h1234, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (r_lat !== 1) begin n_bad++; $display("FAIL div0_latency got %0d want 1", r_lat); end
    n_cmp++; if ({r_hi, r_lo} !== 64'h00001234_FFFFFFFF) begin
      n_bad++; $display("FAIL div0_result got %h want 00001234ffffffff", {r_hi, r_lo}); end
    n_cmp++; if ({r_hw, r_lw, r_dz} !== 3'b111) begin
      n_bad++; $display("FAIL div0_flags got %b want 111", {r_hw, r_lw, r_dz}); end
    n_cmp++; if (n_dn !== 1'b0) begin n_bad++; $display("FAIL div0_done_pulse got %b want 0", n_dn); end
  endtask

  // Runs right after the div-by-zero case, so LO is known to be all ones.
  task automatic test_move;
    run_op(OP_MTHI, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (r_lat !== 1) begin n_bad++; $display("FAIL mthi_latency got %0d want 1", r_lat); end
    n_cmp++; if ({r_hw, r_lw, r_dz} !== 3'b100) begin
      n_bad++; $display("FAIL mthi_strobes got %b want 100", {r_hw, r_lw, r_dz}); end
    n_cmp++; if ({r_hi, r_lo} !== 64'hCAFEF00D_FFFFFFFF) begin
      n_bad++; $display("FAIL mthi_data got %h want cafef00dffffffff", {r_hi, r_lo}); end
    run_op(OP_MTLO, 32'h0BADF00D, 32'h0, 32'h0, 32'h0);
    n_cmp++; if ({r_hw, r_lw} !== 2'b01) begin
      n_bad++; $display("FAIL mtlo_strobes got %b want 01", {r_hw, r_lw}); end
    n_cmp++; if ({r_hi, r_lo} !== 64'hCAFEF00D_0BADF00D) begin
      n_bad++; $display("FAIL mtlo_data got %h want cafef00d0badf00d", {r_hi, r_lo}); end
  endtask

  task automatic test_madd_msub;
    run_op(OP_MADD, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFF);
    n_cmp++; if ({r_hi, r_lo} !== 64'h00000001_00000005) begin
      n_bad++; $display("FAIL madd_result got %h want 0000000100000005", {r_hi, r_lo}); end
    run_op(OP_MSUB, 32'd1, 32'd1, 32'h0, 32'h0);
    n_cmp++; if ({r_hi, r_lo} !== 64'hFFFFFFFF_FFFFFFFF) begin
      n_bad++; $display("FAIL msub_result got %h want ffffffffffffffff", {r_hi, r_lo}); end
  endtask

  // Start held high: WB, one IDLE cycle, then the second op's WB.
  task automatic test_back_to_back;
    @(negedge Clk);
    Start = 1'b1; Op = OP_MTHI; A = 32'h11111111;
    @(posedge Clk);
    #1 Op = OP_MTLO; A = 32'h22222222;
    @(negedge Clk);
    n_cmp++; if ({Done, HIWrite, LOWrite, outHigh} !== {3'b110, 32'h11111111}) begin
      n_bad++; $display("FAIL b2b_first got %b/%h want 110/11111111", {Done, HIWrite, LOWrite}, outHigh); end
    @(negedge Clk);
    n_cmp++; if ({Busy, Done} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_idle got %b want 00", {Busy, Done}); end
    @(negedge Clk);
    n_cmp++; if ({Done, HIWrite, LOWrite, outHigh, outLow} !== {3'b101, 32'h11111111, 32'h22222222}) begin
      n_bad++; $display("FAIL b2b_second got %b/%h/%h want 101/11111111/22222222",
                        {Done, HIWrite, LOWrite}, outHigh, outLow); end
    Start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_busy_start;
    int lat;
    logic [31:0] hi, lo;
    logic hw, lw;
    lat = -1; hi = 'x; lo = 'x; hw = 'x; lw = 'x;
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge Clk);
      if (k == 5) begin Start = 1'b1; Op = OP_MTHI; A = 32'hDEADBEEF; B = 32'h0; end
      if (k == 6) Start = 1'b0;
      if (Done) begin lat = k; hi = outHigh; lo = outLow; hw = HIWrite; lw = LOWrite; break; end
    end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL busy_start_latency got %0d want 34", lat); end
    n_cmp++; if ({hw, lw, hi, lo} !== {2'b11, 32'd2, 32'd14}) begin
      n_bad++; $display("FAIL busy_start_result got %b/%h/%h want 11/00000002/0000000e", {hw, lw}, hi, lo); end
    @(negedge Clk);
  endtask

  task automatic test_reset_midop;
    int strobes;
    strobes = 0;
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULT; A = 32'h7; B = 32'h9;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    #1;
    n_cmp++; if ({Busy, Done, HIWrite, LOWrite, DivByZero} !== 5'b0) begin
      n_bad++; $display("FAIL midop_reset_ctrl got %b want 00000", {Busy, Done, HIWrite, LOWrite, DivByZero}); end
    n_cmp++; if ({outHigh, outLow} !== 64'h0) begin
      n_bad++; $display("FAIL midop_reset_data got %h want 0", {outHigh, outLow}); end
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done || HIWrite || LOWrite || Busy) strobes++;
    end
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL midop_no_strobe got %0d want 0", strobes); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_by_zero;
    test_move;
    test_madd_msub;
    test_back_to_back;
    test_busy_start;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide engine for the MIPS pipeline; sits directly upstream of the HI/LO register pair.
- Accepts one MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO op from EX, computes over multiple cycles, then presents the 64-bit result for one cycle with HI/LO write strobes.
- Busy stalls the pipeline while an op is in flight.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- ITERS, WIDTH, iteration count of the shift-add / restoring-divide loop.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  launch op; sampled only in IDLE.
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- A  in  WIDTH  rs operand (multiplicand/dividend; source for MTHI/MTLO).
- B  in  WIDTH  rt operand (multiplier/divisor).
- HIIn  in  WIDTH  current HI, used by MADD/MSUB.
- LOIn  in  WIDTH  current LO, used by MADD/MSUB.
- Busy  out  1  op in flight; pipeline stall request.
- Done  out  1  one-cycle pulse in WB state.
- outHigh  out  WIDTH  value for HI register.
- outLow  out  WIDTH  value for LO register.
- HIWrite  out  1  HI write strobe, one cycle.
- LOWrite  out  1  LO write strobe, one cycle.
- DivByZero  out  1  high with Done when DIV/DIVU had B==0.

Behaviour:
- Reset (async, Rst=1): state IDLE; Busy, Done, HIWrite, LOWrite, DivByZero = 0; outHigh = outLow = 0; internal accumulators cleared. Reset mid-op aborts with no write strobe.
- States: IDLE, CALC, FIX, WB.
- IDLE:
  - Start=1 at edge T captures Op, A, B, HIIn, LOIn.
  - MTHI/MTLO go to WB; all others go to CALC, except DIV/DIVU with B==0, which go to WB.
  - Busy=0 in IDLE, 1 in CALC/FIX/WB.
- CALC:
  - ITERS cycles, one bit per cycle, using counter 0..ITERS-1.
  - Signed ops (MULT, DIV, MADD, MSUB) iterate on magnitudes; original signs are recorded.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, giving 32-bit quotient and remainder.
- FIX (1 cycle):
  - Apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
  - MADD adds the 64-bit product to {HIIn,LOIn}; MSUB subtracts it. Wraps mod 2^64, no overflow flag.
- WB (1 cycle):
  - outHigh/outLow registered, Done=1.
  - Mult/div ops: HIWrite=LOWrite=1. MTHI: HIWrite=1 only, outHigh=A. MTLO: LOWrite=1 only, outLow=A.
  - Next state IDLE.
- Latency: Start at edge T gives the WB cycle T+ITERS+2 (T+34 by default) for arithmetic ops, and T+1 for MTHI/MTLO/div-by-zero. New Start accepted at the edge ending WB+0 (IDLE next cycle).
- Divide results: LO = quotient, HI = remainder.
- Div by zero: LO = all ones, HI = A, DivByZero=1 during WB.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0. No trap.
- Start while Busy is ignored; captured operands are not disturbed.
- Outside WB, strobes stay 0; outHigh/outLow hold their last WB value.

Decomposition:
- Shared package (muldiv_pkg):
  - Op code constants (OP_MULT..OP_MTLO).
  - State encoding (IDLE, CALC, FIX, WB).
  - WIDTH default.
- Natural sub-module: muldiv_iter_core, holding the per-cycle shift-add / restoring-subtract datapath with counter.
- Top level keeps the FSM, sign fix-up, MADD/MSUB accumulate and output registers.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> at T+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, both strobes 1 for exactly one cycle, Busy high T+1..T+34.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> at T+1: LO=0xFFFFFFFF, HI=0x1234, DivByZero=1, Done=1.
- MADD HIIn=0, LOIn=0xFFFFFFFF, A=2, B=3 -> HI=1, LO=5. MSUB HIIn=0, LOIn=0, A=1, B=1 -> HI=LO=0xFFFFFFFF.
- MTHI A=0xCAFEF00D -> at T+1: HIWrite=1, LOWrite=0, outHigh=0xCAFEF00D. MTLO gives the mirror result.
- Assert Rst at CALC cycle 10 of a MULT -> all outputs 0 immediately, no strobe afterwards. Start pulsed during Busy -> ignored, original result unchanged.
